// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter:
// FSM encoding, requester count and select width.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational wrap-around picker: first set request scanning upward
// from ptr, wrapping 3 -> 0.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest-to-ptr request wins.
  always_comb begin
    any  = |req;
    idx  = ptr;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter granting one of four requesters a multi-cycle burst on
// a shared DATA_W-bit bus, with a MAX_HOLD timeout that forces release.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  input  logic [DATA_W-1:0]  data0,
  input  logic [DATA_W-1:0]  data1,
  input  logic [DATA_W-1:0]  data2,
  input  logic [DATA_W-1:0]  data3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic [DATA_W-1:0]  bus_out,
  output logic               timeout,
  output arb_state_e         dbg_state
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  // Handshake: req[i] is a level held until the burst is done; gnt is a
  // registered one-hot; a beat transfers on every cycle gnt[i] is high, and
  // the burst ends on the beat where last=1 (or when req[sel] drops / timeout).

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;

  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               hold_hit;
  logic               release_now;

  // While owning, the next winner is searched from sel+1 so the current owner
  // ranks last; in IDLE the stored pointer is used.
  assign pick_ptr = (state_q == ST_OWN) ? sel_q + SEL_W'(1) : ptr_q;

  rr_pick4 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign hold_hit    = (hold_q == HOLD_W'(MAX_HOLD));
  assign release_now = last || !req[sel_q] || hold_hit;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_OWN;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          sel_d   = pick_idx;
          hold_d  = HOLD_W'(1);
        end
      end
      ST_OWN: begin
        if (release_now) begin
          ptr_d     = sel_q + SEL_W'(1);
          // A burst that ends normally on the same beat is not a timeout.
          timeout_d = hold_hit && !last && req[sel_q];
          if (pick_any) begin
            gnt_d  = NUM_REQ'(1) << pick_idx;
            sel_d  = pick_idx;
            hold_d = HOLD_W'(1);
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (hold_q != '1) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    bus_out = '0;
    if (busy) begin
      case (sel_q)
        2'd0:    bus_out = data0;
        2'd1:    bus_out = data1;
        2'd2:    bus_out = data2;
        default: bus_out = data3;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = |gnt_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule
